// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: sizing of the occupancy counter.
package elastic_pipe_pkg;

    // Bits needed to represent an occupancy from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One register stage of the elastic pipeline: a valid bit plus a data word that
// loads from upstream when the stage is allowed to advance.
module elastic_stage #(
    parameter int                 width_p     = 10,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o
);

    logic               valid_q;
    logic               valid_d;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = reset_val_p;
        end else if (load_i) begin
            valid_d = valid_i;
            // A bubble moving in leaves the previous word in place.
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= reset_val_p;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// Bubble-collapsing valid/ready register pipeline with synchronous flush and a
// registered occupancy count.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int                 width_p     = 10,
    parameter int                 depth_p     = 2,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             flush_i,
    input  logic                             valid_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    output logic                             valid_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             ready_i,
    output logic [count_width(depth_p)-1:0]  count_o
);

    localparam int CountW = count_width(depth_p);

    if (depth_p < 1) begin : g_bad_depth
        $error("elastic_pipe: depth_p must be at least 1");
    end
    if (width_p < 1) begin : g_bad_width
        $error("elastic_pipe: width_p must be at least 1");
    end

    logic [depth_p-1:0] v_w;
    logic [depth_p-1:0] r_w;
    logic [width_p-1:0] d_w [depth_p];
    logic               in_xfer;
    logic               out_xfer;
    logic [CountW-1:0]  count_q;
    logic [CountW-1:0]  count_d;

    // Stage k may advance when downstream is ready or any stage from k to the
    // head is empty; written as a reduction to avoid a combinational chain on
    // a single vector.
    for (genvar gi = 0; gi < depth_p; gi++) begin : g_ready
        assign r_w[gi] = ready_i | ~(&v_w[depth_p-1:gi]);
    end

    assign ready_o  = r_w[0] & ~flush_i & reset_ni;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    for (genvar gi = 0; gi < depth_p; gi++) begin : g_stage
        logic               up_valid;
        logic [width_p-1:0] up_data;

        if (gi == 0) begin : g_head_in
            assign up_valid = in_xfer;
            assign up_data  = data_i;
        end else begin : g_chain
            assign up_valid = v_w[gi-1];
            assign up_data  = d_w[gi-1];
        end

        elastic_stage #(
            .width_p     (width_p),
            .reset_val_p (reset_val_p)
        ) u_stage (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .flush_i  (flush_i),
            .load_i   (r_w[gi]),
            .valid_i  (up_valid),
            .data_i   (up_data),
            .valid_o  (v_w[gi]),
            .data_o   (d_w[gi])
        );
    end

    assign valid_o = v_w[depth_p-1];
    assign data_o  = d_w[depth_p-1];

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CountW'(in_xfer) - CountW'(out_xfer);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    // The counter is a cheap registered shadow of the valid bits.
    a_count_matches_valids: assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        count_q == CountW'($countones(v_w))
    );

    a_count_bounded: assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        count_q <= CountW'(depth_p)
    );

endmodule

// File: tb/tb_elastic_pipe.sv
// Randomised and directed checks of elastic_pipe against a word/position model.
module tb_elastic_pipe;

    localparam int W = 10;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);
    localparam logic [W-1:0] RST = 10'h155;

    logic          clk;
    logic          reset_ni;
    logic          flush_i;
    logic          valid_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          ready_i;
    logic [CW-1:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    elastic_pipe #(
        .width_p     (W),
        .depth_p     (D),
        .reset_val_p (RST)
    ) u_dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .ready_i  (ready_i),
        .count_o  (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each held word has a position (0 = input side, D-1 = head).
    // A word steps forward when downstream accepts or any later slot is empty.
    typedef struct {
        logic [W-1:0] d;
        int           p;
    } word_t;

    word_t        mq[$];
    logic [W-1:0] m_head;

    function automatic bit m_ready();
        return !flush_i && ((mq.size() < D) || ready_i);
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].p == D - 1);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_head = RST;
    endtask

    task automatic model_edge();
        bit occ [D];
        bit in_x;
        bit out_x;
        bit adv;
        for (int j = 0; j < D; j++) occ[j] = 1'b0;
        foreach (mq[i]) occ[mq[i].p] = 1'b1;
        in_x  = valid_i && m_ready();
        out_x = m_valid() && ready_i;
        if (flush_i) begin
            model_clear();
            return;
        end
        if (out_x) void'(mq.pop_front());
        foreach (mq[i]) begin
            adv = ready_i;
            for (int j = mq[i].p + 1; j < D; j++) if (!occ[j]) adv = 1'b1;
            if (adv) begin
                mq[i].p = mq[i].p + 1;
                if (mq[i].p == D - 1) m_head = mq[i].d;
            end
        end
        if (in_x) begin
            mq.push_back('{d: data_i, p: 0});
            if (D == 1) m_head = data_i;
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy, input bit fl);
        valid_i = v;
        data_i  = d;
        ready_i = rdy;
        flush_i = fl;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        drive(0, '0, 0, 0);
        model_clear();
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        drive(1, 10'h3C3, 1, 0);
        model_clear();
        @(negedge clk);
        n_checks++;
        if ({ready_o, valid_o, count_o} !== {1'b0, 1'b0, CW'(0)} || data_o !== RST) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b cnt=%0d data=%h, expected rdy=0 vld=0 cnt=0 data=%h",
                     ready_o, valid_o, count_o, data_o, RST);
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        drive(0, '0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1 || count_o !== CW'(0)) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b cnt=%0d, expected rdy=1 cnt=0", ready_o, count_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        do_reset();
        drive(1, 10'h2A1, 1, 0);
        advance();
        drive(0, '0, 1, 0);
        for (int c = 1; c <= D + 1; c++) begin
            @(negedge clk);
            n_checks++;
            if (valid_o !== (c == D) || count_o !== CW'((c <= D) ? 1 : 0) ||
                ((c == D) && data_o !== 10'h2A1)) begin
                n_fail++;
                $display("FAIL latency cycle %0d: got vld=%b cnt=%0d data=%h, expected vld=%b cnt=%0d data=2a1",
                         c, valid_o, count_o, data_o, (c == D), (c <= D) ? 1 : 0);
            end
            advance();
        end
        $display("test_latency done");
    endtask

    task automatic test_fill();
        int next_w;
        int exp_out;
        bit started;
        do_reset();
        next_w = 1;
        for (int c = 0; c < 8; c++) begin
            drive(1, W'(next_w), 0, 0);
            @(negedge clk);
            n_checks++;
            if (ready_o !== (c < D) || count_o !== CW'((c < D) ? c : D)) begin
                n_fail++;
                $display("FAIL fill cycle %0d: got rdy=%b cnt=%0d, expected rdy=%b cnt=%0d",
                         c, ready_o, count_o, (c < D), (c < D) ? c : D);
            end
            advance();
            if (c < D) next_w++;
        end
        exp_out = 1;
        started = 1'b0;
        for (int c = 0; c < 30 && exp_out <= 6; c++) begin
            drive(next_w <= 6, W'(next_w), 1, 0);
            @(negedge clk);
            n_checks++;
            if (count_o > CW'(D) || (started && valid_o !== 1'b1) ||
                (valid_o === 1'b1 && data_o !== W'(exp_out))) begin
                n_fail++;
                $display("FAIL drain cycle %0d: got vld=%b data=%0d cnt=%0d, expected vld=1 data=%0d cnt<=%0d",
                         c, valid_o, data_o, count_o, exp_out, D);
            end
            if (valid_o === 1'b1) begin
                started = 1'b1;
                exp_out++;
            end
            if (ready_o === 1'b1 && next_w <= 6) next_w++;
            advance();
        end
        n_checks++;
        if (exp_out != 7) begin
            n_fail++;
            $display("FAIL drain_complete: got %0d words, expected 6", exp_out - 1);
        end
        $display("test_fill done");
    endtask

    task automatic test_bubble();
        do_reset();
        drive(1, 10'h0A5, 0, 0);
        advance();
        drive(0, '0, 0, 0);
        advance();
        advance();
        drive(1, 10'h0B6, 0, 0);
        advance();
        drive(0, '0, 0, 0);
        advance();
        advance();
        @(negedge clk);
        n_checks++;
        if ({ready_o, valid_o, count_o} !== {1'b1, 1'b1, CW'(2)} || data_o !== 10'h0A5) begin
            n_fail++;
            $display("FAIL bubble_compact: got rdy=%b vld=%b cnt=%0d data=%h, expected rdy=1 vld=1 cnt=2 data=0a5",
                     ready_o, valid_o, count_o, data_o);
        end
        drive(0, '0, 1, 0);
        advance();
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 10'h0B6 || count_o !== CW'(1)) begin
            n_fail++;
            $display("FAIL bubble_adjacent: got vld=%b data=%h cnt=%0d, expected vld=1 data=0b6 cnt=1",
                     valid_o, data_o, count_o);
        end
        advance();
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== CW'(0)) begin
            n_fail++;
            $display("FAIL bubble_empty: got vld=%b cnt=%0d, expected vld=0 cnt=0", valid_o, count_o);
        end
        $display("test_bubble done");
    endtask

    task automatic test_full_pass();
        logic [W-1:0] exp_q[$];
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, W'(10'h100 + i), 0, 0);
            exp_q.push_back(W'(10'h100 + i));
            advance();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, W'(10'h200 + i), 1, 0);
            exp_q.push_back(W'(10'h200 + i));
            @(negedge clk);
            n_checks++;
            if ({ready_o, valid_o, count_o} !== {1'b1, 1'b1, CW'(D)} || data_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL full_pass cycle %0d: got rdy=%b vld=%b cnt=%0d data=%h, expected rdy=1 vld=1 cnt=%0d data=%h",
                         i, ready_o, valid_o, count_o, data_o, D, exp_q[0]);
            end
            void'(exp_q.pop_front());
            advance();
        end
        $display("test_full_pass done");
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1, W'(10'h010 + i), 0, 0);
            advance();
        end
        drive(0, '0, 0, 0);
        advance();
        drive(1, 10'h3FF, 1, 1);
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 10'h011 || count_o !== CW'(3)) begin
            n_fail++;
            $display("FAIL flush_cycle: got rdy=%b vld=%b data=%h cnt=%0d, expected rdy=0 vld=1 data=011 cnt=3",
                     ready_o, valid_o, data_o, count_o);
        end
        advance();
        drive(0, '0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== CW'(0) || data_o !== RST) begin
            n_fail++;
            $display("FAIL flush_after: got vld=%b cnt=%0d data=%h, expected vld=0 cnt=0 data=%h",
                     valid_o, count_o, data_o, RST);
        end
        for (int i = 0; i < D; i++) advance();
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== CW'(0)) begin
            n_fail++;
            $display("FAIL flush_no_capture: got vld=%b cnt=%0d, expected vld=0 cnt=0", valid_o, count_o);
        end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 10'h0C1, 0, 0);
        advance();
        drive(1, 10'h0C2, 0, 0);
        advance();
        drive(0, '0, 0, 0);
        advance();
        advance();
        @(negedge clk);
        #2;
        reset_ni = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({ready_o, valid_o, count_o} !== {1'b0, 1'b0, CW'(0)} || data_o !== RST) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b cnt=%0d data=%h, expected rdy=0 vld=0 cnt=0 data=%h",
                     ready_o, valid_o, count_o, data_o, RST);
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        drive(1, 10'h0AA, 1, 0);
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_resume_ready: got rdy=%b, expected rdy=1", ready_o);
        end
        advance();
        drive(0, '0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (count_o !== CW'(1)) begin
            n_fail++;
            $display("FAIL async_resume_count: got cnt=%0d, expected cnt=1", count_o);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        bit           hold;
        bit           v;
        logic [W-1:0] d;
        bit           e_rdy;
        bit           e_vld;
        do_reset();
        hold = 1'b0;
        v    = 1'b0;
        d    = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                v = ($urandom % 3) != 0;
                d = W'($urandom);
            end
            drive(v, d, ($urandom % 4) != 0, ($urandom % 25) == 0);
            @(negedge clk);
            e_rdy = m_ready();
            e_vld = m_valid();
            n_checks++;
            if (ready_o !== e_rdy || valid_o !== e_vld || data_o !== m_head ||
                count_o !== CW'(mq.size())) begin
                n_fail++;
                $display("FAIL random cycle %0d: got rdy=%b vld=%b data=%h cnt=%0d, expected rdy=%b vld=%b data=%h cnt=%0d",
                         c, ready_o, valid_o, data_o, count_o, e_rdy, e_vld, m_head, mq.size());
            end
            hold = v && !e_rdy;
            advance();
        end
        $display("test_random done");
    endtask

    initial begin
        reset_ni = 1'b0;
        drive(0, '0, 0, 0);
        model_clear();
        test_reset();
        test_latency();
        test_fill();
        test_bubble();
        test_full_pass();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
